gf_sqrt_iter: RTL and testbench
===============================

Name: gf_sqrt_iter

Overview:
- Sequential GF(2^N) square-root unit; the inverse of the field squarer.
- Computes out = in^(2^(N-1)), which is the unique square root in GF(2^N).
- It does this by N-1 iterative squarings modulo a runtime primitive polynomial, one squaring per clock.
- Sits beside the combinational squarer in the GF arithmetic library; used by RS/BCH decoder datapaths that need field roots.

Parameters:
- N, 8: field degree. Must be >= 2; values below 2 are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- in  input  N  operand, captured when start is accepted.
- prim  input  N+1  primitive polynomial, bit N = 1 (e.g. 9'h11d); captured when start is accepted.
- busy  output  1  high while a computation is in progress (RUN or DONE).
- done  output  1  one-cycle pulse; out is valid in the same cycle.
- out  output  N  square root; holds its value until the next accepted start.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, out=0, internal acc=0, cnt=0, latched prim=0.
- States: IDLE, RUN, DONE. The register update sq(x) is defined as (x*x) mod prim_latched.
- sq(x) is computed in-block: spread the bits of x to even positions (2N-1 bits), then reduce from bit 2N-2 down to bit N by XOR of prim_latched shifted left.
- IDLE:
  - If start=1: acc<=in, prim_latched<=prim, cnt<=N-1, go to RUN, busy<=1.
  - Otherwise remain in IDLE.
- RUN:
  - Each edge: acc<=sq(acc), cnt<=cnt-1.
  - When cnt==1 at the edge: out<=sq(acc), done<=1, go to DONE.
- DONE:
  - done returns to 0 on the next edge, busy<=0, go to IDLE.
  - An accepted start is therefore possible on the edge after the DONE cycle.
- Latency: start sampled at edge E0; done=1 and out valid after edge E0+(N-1). For N=8 this is 7 cycles.
  - Throughput is one result per N+1 cycles when start is held high continuously.
- start during RUN/DONE: ignored. No queuing, and in/prim changes have no effect.
- in/prim may change freely after acceptance, because both are latched.
- Zero operand: in=0 gives out=0. in=1 gives out=1.
- prim with bit N=0: unsupported; the result is undefined but the FSM must still complete normally and assert done.
- rst asserted mid-RUN: the operation is abandoned immediately, all outputs take their reset values, and no done pulse is produced.
- cnt width: $clog2(N) bits minimum; it must hold N-1 without overflow.

Optional Feature:
- Macro: GF_SQRT_CHECK_EN
- With the macro defined:
  - Adds output port chk_err (1 bit, reset 0).
  - The original operand is kept in a shadow register.
  - In the DONE cycle, chk_err = (sq(out) != shadow); it is high only in the DONE cycle, otherwise 0.
  - Intended for self-checking in silicon/FPGA debug builds.
- Without the macro: no chk_err port and no shadow register; the remaining behaviour is identical.

Test Plan:
- Reset then basic root: rst pulse, then prim=9'h11d, in=8'h3c, start for 1 cycle -> done pulses exactly 7 cycles after the start edge, with out=8'h3f (since 0x3f^2 = 0x3c mod 0x11d).
- Simple roots: in=8'h04 -> out=8'h02; in=8'h10 -> out=8'h04; in=8'h00 -> out=8'h00; in=8'h01 -> out=8'h01.
- Busy protection: start with in=8'h3c, then pulse start with in=8'h04 while busy=1 -> only one done pulse, out=8'h3f; next accepted start with in=8'h04 gives 8'h02.
- Operand latching: change in and prim every cycle during RUN -> out still equals the root of the value latched at start.
- Reset mid-operation: assert rst 3 cycles after start -> busy, done and out are 0 immediately; no done pulse follows; a fresh start with in=8'h3c yields 8'h3f.
- Exhaustive: for all 256 inputs with prim=9'h11d, the squarer model applied to out equals in. With GF_SQRT_CHECK_EN defined, chk_err stays 0 throughout.

Source files
------------

// File: rtl/gf_sqrt_iter.sv
// gf_sqrt_iter: sequential GF(2^N) square root.
// Computes out = in^(2^(N-1)) by N-1 modular squarings, one per clock,
// against a primitive polynomial latched with the operand.
// Optional build macro GF_SQRT_CHECK_EN adds chk_err, which flags a result
// whose square does not reproduce the latched operand.
module gf_sqrt_iter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] in,
  input  logic [N:0]   prim,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out
`ifdef GF_SQRT_CHECK_EN
  ,
  output logic         chk_err
`endif
);

  // Counter only has to reach N-1, so $clog2(N) bits suffice.
  localparam int unsigned CW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [N:0]    prim_l;
  logic [N-1:0]  acc_sq;

  // Field squaring: spread x onto even bit positions, then reduce the
  // upper terms from bit 2N-2 down to bit N with shifted copies of p.
  function automatic logic [N-1:0] sq(input logic [N-1:0] x, input logic [N:0] p);
    logic [2*N-2:0] t;
    logic [2*N-2:0] pe;
    int unsigned    k;
    t  = '0;
    pe = '0;
    pe[N:0] = p;
    for (int unsigned i = 0; i < N; i++) begin
      t[2*i] = x[i];
    end
    for (int unsigned j = 0; j < N - 1; j++) begin
      k = 2*N - 2 - j;
      if (t[k]) begin
        t = t ^ (pe << (k - N));
      end
    end
    return t[N-1:0];
  endfunction

  // Next value of the accumulator.
  always_comb begin
    acc_sq = sq(acc, prim_l);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      out    <= '0;
      acc    <= '0;
      cnt    <= '0;
      prim_l <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc    <= in;
            prim_l <= prim;
            cnt    <= CW'(N - 1);
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_sq;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            out   <= acc_sq;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GF_SQRT_CHECK_EN
  logic [N-1:0] shadow;

  // Keep the original operand for the result self-check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (state == S_IDLE && start) begin
      shadow <= in;
    end
  end

  // Squaring the root must give back the operand; only meaningful in DONE.
  always_comb begin
    chk_err = (state == S_DONE) && (sq(out, prim_l) != shadow);
  end
`endif

endmodule

// File: tb/tb_gf_sqrt_iter.sv
// Self-checking bench for gf_sqrt_iter (N=8): directed roots, busy
// protection, operand latching, mid-operation reset, exhaustive and
// randomized roots against a root-search reference model.
module tb_gf_sqrt_iter;

  localparam int unsigned N = 8;
  localparam int LAT = N - 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] in_s;
  logic [N:0]   prim_s;
  logic         busy;
  logic         done;
  logic [N-1:0] out;
`ifdef GF_SQRT_CHECK_EN
  logic         chk_err;
  int           chk_hits;
`endif

  int checks;
  int failures;
  int done_count;

  gf_sqrt_iter #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in_s),
    .prim  (prim_s),
    .busy  (busy),
    .done  (done),
    .out   (out)
`ifdef GF_SQRT_CHECK_EN
    ,
    .chk_err (chk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses (sampled mid-cycle).
  always @(negedge clk) begin
    if (done) done_count++;
`ifdef GF_SQRT_CHECK_EN
    if (chk_err) chk_hits++;
`endif
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: schoolbook GF(2^N) product with polynomial p.
  function automatic int gmul(input int a, input int b, input int p);
    int r;
    r = 0;
    for (int i = N - 1; i >= 0; i--) begin
      r = r << 1;
      if (r & (1 << N)) r = r ^ p;
      if (b & (1 << i)) r = r ^ a;
    end
    return r;
  endfunction

  // Reference root: the element whose square is x.
  function automatic int groot(input int x, input int p);
    for (int y = 0; y < (1 << N); y++) begin
      if (gmul(y, y, p) == x) return y;
    end
    return -1;
  endfunction

  // One operation; lat is the number of edges from accept to done (-1 on timeout).
  task automatic run_op(input logic [N-1:0] a, input logic [N:0] p, input bit perturb,
                        output logic [N-1:0] res, output int lat);
    @(negedge clk);
    in_s   = a;
    prim_s = p;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("busy_after_accept", busy, 1);
    lat = -1;
    for (int c = 1; c <= 3 * N; c++) begin
      if (perturb) begin
        in_s   = N'($urandom);
        prim_s = (N + 1)'($urandom);
      end
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    res = out;
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", done, 0);
    check_eq("busy_cleared", busy, 0);
  endtask

  logic [N-1:0] res;
  int           lat;
  int           dc0;
  int           ok;
  logic [N:0]   prims [16];

  initial begin
    checks = 0; failures = 0; done_count = 0;
`ifdef GF_SQRT_CHECK_EN
    chk_hits = 0;
`endif
    prims = '{9'h11d, 9'h12b, 9'h12d, 9'h14d, 9'h15f, 9'h163, 9'h165, 9'h169,
              9'h171, 9'h187, 9'h18d, 9'h1a9, 9'h1c3, 9'h1cf, 9'h1e7, 9'h1f5};
    rst = 1'b1; start = 1'b0; in_s = '0; prim_s = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_out", out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic root with exact latency.
    run_op(8'h3c, 9'h11d, 1'b0, res, lat);
    check_eq("basic_lat", lat, LAT);
    check_eq("basic_out", res, 8'h3f);

    // Simple roots.
    run_op(8'h04, 9'h11d, 1'b0, res, lat);
    check_eq("root_04", res, 8'h02);
    run_op(8'h10, 9'h11d, 1'b0, res, lat);
    check_eq("root_10", res, 8'h04);
    run_op(8'h00, 9'h11d, 1'b0, res, lat);
    check_eq("root_00", res, 8'h00);
    check_eq("root_00_lat", lat, LAT);
    run_op(8'h01, 9'h11d, 1'b0, res, lat);
    check_eq("root_01", res, 8'h01);

    // Busy protection: starts during RUN and DONE are ignored.
    @(negedge clk);
    in_s = 8'h3c; prim_s = 9'h11d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dc0 = done_count;
    repeat (2) @(posedge clk);
    #1;
    in_s = 8'h04; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ok = 0;
    for (int c = 0; c < 3 * N; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ok = 1;
        break;
      end
    end
    check_eq("busy_prot_done_seen", ok, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("busy_prot_out", out, 8'h3f);
    repeat (12) @(posedge clk);
    #1;
    check_eq("busy_prot_pulses", done_count - dc0, 1);
    check_eq("busy_prot_idle", busy, 0);
    run_op(8'h04, 9'h11d, 1'b0, res, lat);
    check_eq("busy_prot_next", res, 8'h02);

    // Operand latching: inputs churn every cycle during RUN.
    for (int t = 0; t < 6; t++) begin
      logic [N-1:0] a;
      logic [N:0]   p;
      a = N'($urandom);
      p = prims[$urandom_range(0, 15)];
      run_op(a, p, 1'b1, res, lat);
      check_eq("latch_out", res, groot(a, p));
      check_eq("latch_lat", lat, LAT);
    end

    // Reset mid-operation.
    run_op(8'h3c, 9'h11d, 1'b0, res, lat);
    @(negedge clk);
    in_s = 8'h10; prim_s = 9'h11d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_out", out, 0);
    @(negedge clk);
    rst = 1'b0;
    dc0 = done_count;
    repeat (12) @(posedge clk);
    #1;
    check_eq("midrst_no_done", done_count - dc0, 0);
    run_op(8'h3c, 9'h11d, 1'b0, res, lat);
    check_eq("midrst_fresh", res, 8'h3f);

    // Exhaustive over all operands with 0x11d.
    for (int x = 0; x < (1 << N); x++) begin
      run_op(N'(x), 9'h11d, 1'b0, res, lat);
      check_eq("exh_square", gmul(int'(res), int'(res), 'h11d), x);
    end

    // Randomized operands and polynomials.
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] a;
      logic [N:0]   p;
      a = N'($urandom);
      p = prims[$urandom_range(0, 15)];
      run_op(a, p, 1'b0, res, lat);
      check_eq("rand_root", res, groot(a, p));
    end

`ifdef GF_SQRT_CHECK_EN
    check_eq("chk_err_hits", chk_hits, 0);
`endif

    // Unsupported polynomial (bit N clear): must still complete.
    run_op(8'h5a, 9'h01d, 1'b0, res, lat);
    check_eq("badprim_lat", lat, LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
